// File: rtl/udb_counter.sv
// Parametrised multi-digit BCD up/down counter with configurable top-digit modulus,
// clear/load with BCD validation, wrap or saturate at terminal value, cascade output.
module udb_counter #(
    parameter int DIGITS   = 4,
    parameter int MAX_TOP  = 9,
    parameter int SATURATE = 0
) (
    input  logic                  udb_clk,
    input  logic                  udb_rst_n,
    input  logic                  udb_en,
    input  logic                  udb_up,
    input  logic                  udb_clr,
    input  logic                  udb_load,
    input  logic [4*DIGITS-1:0]   udb_load_val,
    output logic [4*DIGITS-1:0]   udb_out,
    output logic                  udb_tc,
    output logic                  udb_wrap,
    output logic                  udb_load_err
);

    localparam int unsigned TOP_IDX = DIGITS - 1;
    localparam logic [3:0]  TOP_LIM = 4'(MAX_TOP);

    function automatic logic [3:0] digit_lim(input int unsigned idx);
        return (idx == TOP_IDX) ? TOP_LIM : 4'd9;
    endfunction

    logic [4*DIGITS-1:0] cnt_next;
    logic [4*DIGITS-1:0] load_fix;
    logic                load_bad;
    logic                ripple;
    logic                at_term;
    logic [3:0]          dig;
    logic [3:0]          lim;

    // A ripple flag walks up the digits: a digit steps only while every lower digit sat
    // at its rollover value. Surviving past the top digit means the counter is at terminal.
    always_comb begin
        cnt_next = udb_out;
        ripple   = 1'b1;
        dig      = '0;
        lim      = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            dig = udb_out[4*i +: 4];
            lim = digit_lim(i);
            if (ripple) begin
                if (udb_up)
                    cnt_next[4*i +: 4] = (dig == lim) ? 4'd0 : dig + 4'd1;
                else
                    cnt_next[4*i +: 4] = (dig == 4'd0) ? lim : dig - 4'd1;
            end
            ripple = ripple & (udb_up ? (dig == lim) : (dig == 4'd0));
        end
        at_term = ripple;
    end

    always_comb begin
        load_fix = '0;
        load_bad = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (udb_load_val[4*i +: 4] > digit_lim(i))
                load_bad = 1'b1;
            else
                load_fix[4*i +: 4] = udb_load_val[4*i +: 4];
        end
    end

    assign udb_tc = udb_en & at_term;

    always_ff @(posedge udb_clk or negedge udb_rst_n) begin
        if (!udb_rst_n) begin
            udb_out      <= '0;
            udb_wrap     <= 1'b0;
            udb_load_err <= 1'b0;
        end else begin
            udb_wrap     <= 1'b0;
            udb_load_err <= 1'b0;
            if (udb_clr) begin
                udb_out <= '0;
            end else if (udb_load) begin
                udb_out      <= load_fix;
                udb_load_err <= load_bad;
            end else if (udb_en) begin
                if (!(at_term && (SATURATE != 0))) begin
                    udb_out  <= cnt_next;
                    udb_wrap <= at_term;
                end
            end
        end
    end

endmodule

// File: tb/tb_udb_counter.sv
// Directed bench for udb_counter: default, saturating, modulus-60 and cascaded builds.
module tb_udb_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        m_en, m_up, m_clr, m_load;
    logic [15:0] m_lv, m_out;
    logic        m_tc, m_wrap, m_err;

    logic        s_en, s_up, s_clr, s_load;
    logic [15:0] s_lv, s_out;
    logic        s_tc, s_wrap, s_err;

    logic        d_en, d_up, d_clr, d_load;
    logic [7:0]  d_lv, d_out;
    logic        d_tc, d_wrap, d_err;

    logic        c_en, c_up, c_clr, c_load;
    logic [3:0]  c_lv, lo_out, hi_out;
    logic        lo_tc, lo_wrap, lo_err, hi_tc, hi_wrap, hi_err;

    int n_checks = 0;
    int n_fail   = 0;

    udb_counter #(.DIGITS(4), .MAX_TOP(9), .SATURATE(0)) u_main (
        .udb_clk(clk), .udb_rst_n(rst_n), .udb_en(m_en), .udb_up(m_up),
        .udb_clr(m_clr), .udb_load(m_load), .udb_load_val(m_lv), .udb_out(m_out),
        .udb_tc(m_tc), .udb_wrap(m_wrap), .udb_load_err(m_err)
    );

    udb_counter #(.DIGITS(4), .MAX_TOP(9), .SATURATE(1)) u_sat (
        .udb_clk(clk), .udb_rst_n(rst_n), .udb_en(s_en), .udb_up(s_up),
        .udb_clr(s_clr), .udb_load(s_load), .udb_load_val(s_lv), .udb_out(s_out),
        .udb_tc(s_tc), .udb_wrap(s_wrap), .udb_load_err(s_err)
    );

    udb_counter #(.DIGITS(2), .MAX_TOP(5), .SATURATE(0)) u_mod (
        .udb_clk(clk), .udb_rst_n(rst_n), .udb_en(d_en), .udb_up(d_up),
        .udb_clr(d_clr), .udb_load(d_load), .udb_load_val(d_lv), .udb_out(d_out),
        .udb_tc(d_tc), .udb_wrap(d_wrap), .udb_load_err(d_err)
    );

    udb_counter #(.DIGITS(1), .MAX_TOP(9), .SATURATE(0)) u_lo (
        .udb_clk(clk), .udb_rst_n(rst_n), .udb_en(c_en), .udb_up(c_up),
        .udb_clr(c_clr), .udb_load(c_load), .udb_load_val(c_lv), .udb_out(lo_out),
        .udb_tc(lo_tc), .udb_wrap(lo_wrap), .udb_load_err(lo_err)
    );

    udb_counter #(.DIGITS(1), .MAX_TOP(9), .SATURATE(0)) u_hi (
        .udb_clk(clk), .udb_rst_n(rst_n), .udb_en(lo_tc), .udb_up(c_up),
        .udb_clr(c_clr), .udb_load(c_load), .udb_load_val(c_lv), .udb_out(hi_out),
        .udb_tc(hi_tc), .udb_wrap(hi_wrap), .udb_load_err(hi_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin : stim
        int tc_seen;
        int wrap_seen;
        int exp_v;

        rst_n = 1'b1;
        m_en = 0; m_up = 1; m_clr = 0; m_load = 0; m_lv = '0;
        s_en = 0; s_up = 1; s_clr = 0; s_load = 0; s_lv = '0;
        d_en = 0; d_up = 1; d_clr = 0; d_load = 0; d_lv = '0;
        c_en = 0; c_up = 1; c_clr = 0; c_load = 0; c_lv = '0;

        // Reset asserted mid-cycle, before any clock edge
        #2 rst_n = 1'b0;
        #1;
        check("reset_out", m_out, 16'h0000);
        check("reset_wrap", m_wrap, 1'b0);
        check("reset_err", m_err, 1'b0);
        step();
        @(negedge clk);
        rst_n = 1'b1;

        // Up-count 1234 clocks from zero
        m_en = 1; m_up = 1;
        tc_seen = 0; wrap_seen = 0;
        for (int k = 0; k < 1234; k++) begin
            step();
            if (m_tc) tc_seen++;
            if (m_wrap) wrap_seen++;
        end
        check("count_1234", m_out, 16'h1234);
        check("count_tc_never", tc_seen, 0);
        check("count_wrap_never", wrap_seen, 0);

        // Load with enable high: no increment on the load edge
        m_load = 1; m_lv = 16'h9998;
        step();
        m_load = 0;
        check("load_9998", m_out, 16'h9998);
        check("load_9998_err", m_err, 1'b0);
        step();
        check("up_9999", m_out, 16'h9999);
        check("up_9999_tc", m_tc, 1'b1);
        check("up_9999_wrap", m_wrap, 1'b0);
        step();
        check("up_wrap_out", m_out, 16'h0000);
        check("up_wrap_pulse", m_wrap, 1'b1);
        check("up_wrap_tc", m_tc, 1'b0);
        step();
        check("up_after_wrap", m_out, 16'h0001);
        check("up_wrap_cleared", m_wrap, 1'b0);

        // Down wrap
        m_up = 0; m_load = 1; m_lv = 16'h0001;
        step();
        m_load = 0;
        check("dn_load", m_out, 16'h0001);
        check("dn_tc_0001", m_tc, 1'b0);
        step();
        check("dn_0000", m_out, 16'h0000);
        check("dn_tc_0000", m_tc, 1'b1);
        step();
        check("dn_wrap_out", m_out, 16'h9999);
        check("dn_wrap_pulse", m_wrap, 1'b1);
        step();
        check("dn_9998", m_out, 16'h9998);
        check("dn_wrap_cleared", m_wrap, 1'b0);

        // Priority: clear over load over enable
        m_clr = 1; m_load = 1; m_en = 1; m_up = 1; m_lv = 16'h1111;
        step();
        check("prio_clr", m_out, 16'h0000);
        m_clr = 0; m_lv = 16'h0500;
        step();
        check("prio_load", m_out, 16'h0500);
        check("prio_load_err", m_err, 1'b0);
        m_load = 0; m_en = 0;
        for (int k = 0; k < 10; k++) step();
        check("hold_10", m_out, 16'h0500);
        check("hold_tc", m_tc, 1'b0);

        // Invalid digits load as zero and flag an error for one cycle
        m_load = 1; m_lv = 16'hA5F3;
        step();
        m_load = 0;
        check("bad_load_out", m_out, 16'h0503);
        check("bad_load_err", m_err, 1'b1);
        step();
        check("bad_load_err_clr", m_err, 1'b0);
        check("bad_load_hold", m_out, 16'h0503);

        // Saturating build, down then up
        s_en = 1; s_up = 0; s_load = 1; s_lv = 16'h0001;
        step();
        s_load = 0;
        check("sat_load", s_out, 16'h0001);
        step();
        check("sat_dn_0000", s_out, 16'h0000);
        check("sat_dn_tc", s_tc, 1'b1);
        step();
        check("sat_dn_hold", s_out, 16'h0000);
        check("sat_dn_tc_hold", s_tc, 1'b1);
        check("sat_dn_wrap", s_wrap, 1'b0);
        step();
        check("sat_dn_hold2", s_out, 16'h0000);
        check("sat_dn_wrap2", s_wrap, 1'b0);
        s_up = 1; s_load = 1; s_lv = 16'h9999;
        step();
        s_load = 0;
        check("sat_up_tc", s_tc, 1'b1);
        step();
        check("sat_up_hold", s_out, 16'h9999);
        check("sat_up_wrap", s_wrap, 1'b0);
        s_en = 0;
        #0;
        #1 check("sat_tc_needs_en", s_tc, 1'b0);

        // Modulus 60 build
        d_en = 1; d_up = 1; d_load = 1; d_lv = 8'h58;
        step();
        d_load = 0;
        check("mod_load_58", d_out, 8'h58);
        step();
        check("mod_59", d_out, 8'h59);
        check("mod_59_tc", d_tc, 1'b1);
        step();
        check("mod_wrap_00", d_out, 8'h00);
        check("mod_wrap_pulse", d_wrap, 1'b1);
        d_up = 0;
        #1 check("mod_dn_tc", d_tc, 1'b1);
        step();
        check("mod_dn_59", d_out, 8'h59);
        check("mod_dn_wrap", d_wrap, 1'b1);
        d_en = 0; d_load = 1; d_lv = 8'h7A;
        step();
        check("mod_bad_out", d_out, 8'h00);
        check("mod_bad_err", d_err, 1'b1);
        d_lv = 8'h42;
        step();
        d_load = 0;
        check("mod_42", d_out, 8'h42);
        check("mod_42_err", d_err, 1'b0);
        d_load = 1; d_lv = 8'h69;
        step();
        d_load = 0;
        check("mod_top_bad", d_out, 8'h09);
        check("mod_top_bad_err", d_err, 1'b1);
        step();
        check("mod_err_pulse", d_err, 1'b0);

        // Reset mid-count overrides immediately and holds across an edge
        m_en = 1; m_up = 1;
        step();
        step();
        check("pre_reset", m_out, 16'h0505);
        #2 rst_n = 1'b0;
        #1 check("midreset_out", m_out, 16'h0000);
        step();
        check("reset_hold_edge", m_out, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("resume_0001", m_out, 16'h0001);
        m_en = 0;

        // Two-stage cascade through udb_tc
        c_en = 1;
        for (int k = 1; k <= 100; k++) begin
            step();
            exp_v = k % 100;
            check("cascade", {24'h0, hi_out, lo_out}, {24'h0, 4'(exp_v / 10), 4'(exp_v % 10)});
            if (k == 99) begin
                check("cascade_lo_tc", lo_tc, 1'b1);
                check("cascade_hi_tc", hi_tc, 1'b1);
            end
            if (k == 100)
                check("cascade_hi_wrap", hi_wrap, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
